// File: rtl/shift_pipe_unit_if.sv
// shift_pipe_unit_if: request/response bundle for the EX-stage shifter.
//   Request  : in_valid/in_ready handshake carrying data, shamt, op, in_tag.
//   Response : out_valid/out_ready handshake carrying dataOut, out_tag.
//   master - the issuing/consuming side (issue logic, result mux).
//   slave  - the shifter itself.
interface shift_pipe_unit_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      data;
  logic [4:0]       shamt;
  logic [1:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      dataOut;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, data, shamt, op, in_tag, out_ready,
    input  in_ready, out_valid, dataOut, out_tag
  );

  modport slave (
    input  in_valid, data, shamt, op, in_tag, out_ready,
    output in_ready, out_valid, dataOut, out_tag
  );
endinterface

// File: rtl/shift_pipe_unit.sv
// shift_pipe_unit: two-stage pipelined 32-bit barrel shifter (SLL/SRL/SRA/ROTR).
//   Stage 1 applies the 16/8-bit levels (shamt[4:3]); stage 2 the 4/2/1-bit
//   levels (shamt[2:0]) and registers the result for the ALU result mux.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst   - asynchronous active-low reset
//   bus   - slave side of shift_pipe_unit_if (request + response handshakes)
//   busy  - high while either stage holds a valid entry
module shift_pipe_unit #(
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  shift_pipe_unit_if.slave    bus,
  output logic                busy
);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  // One barrel level: shift/rotate x by the constant n when en is set.
  // sgn is the operand's original sign bit so SRA fill stays correct even
  // though the level is applied to an already-shifted partial result.
  function automatic logic [31:0] lvl(input logic [31:0] x, input logic en,
                                      input logic [1:0] op, input logic sgn,
                                      input int unsigned n);
    logic [31:0] r;
    logic [31:0] hi_mask;
    r       = x;
    hi_mask = ~(32'hFFFF_FFFF >> n);
    if (en) begin
      case (op)
        OP_SLL:  r = x << n;
        OP_SRL:  r = x >> n;
        OP_SRA:  r = (x >> n) | (hi_mask & {32{sgn}});
        default: r = (x >> n) | (x << (32 - n));
      endcase
    end
    return r;
  endfunction

  // vld_pipe[1] = stage 1 valid, vld_pipe[2] = stage 2 valid (= out_valid)
  logic [STAGES:1]  vld_pipe;
  logic [31:0]      s1_data;
  logic [2:0]       s1_shamt;
  logic [1:0]       s1_op;
  logic             s1_sign;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      s2_data;
  logic [TAG_W-1:0] s2_tag;

  logic s1_adv, s2_adv;
  logic [31:0] l16, l8, l4, l2, l1;

  // Stall chain: a stage may load when it is empty or its successor moves.
  assign s2_adv = !vld_pipe[2] || bus.out_ready;
  assign s1_adv = !vld_pipe[1] || s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = vld_pipe[2];
  assign bus.dataOut   = s2_data;
  assign bus.out_tag   = s2_tag;
  assign busy          = |vld_pipe;

  // Stage 1 combinational levels
  assign l16 = lvl(bus.data, bus.shamt[4], bus.op, bus.data[31], 16);
  assign l8  = lvl(l16,      bus.shamt[3], bus.op, bus.data[31], 8);

  // Stage 2 combinational levels
  assign l4 = lvl(s1_data, s1_shamt[2], s1_op, s1_sign, 4);
  assign l2 = lvl(l4,      s1_shamt[1], s1_op, s1_sign, 2);
  assign l1 = lvl(l2,      s1_shamt[0], s1_op, s1_sign, 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_op    <= '0;
      s1_sign  <= 1'b0;
      s1_tag   <= '0;
      s2_data  <= '0;
      s2_tag   <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= bus.in_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      if (s1_adv && bus.in_valid) begin
        s1_data  <= l8;
        s1_shamt <= bus.shamt[2:0];
        s1_op    <= bus.op;
        s1_sign  <= bus.data[31];
        s1_tag   <= bus.in_tag;
      end
      if (s2_adv && vld_pipe[1]) begin
        s2_data <= l1;
        s2_tag  <= s1_tag;
      end
    end
  end
endmodule

// File: doc/shift_pipe_unit.md
Name: shift_pipe_unit

Overview:
- Two-stage pipelined 32-bit barrel shifter for the EX stage, with a valid/ready handshake.
- Stage 1 applies the 16-bit and 8-bit shift levels (shamt[4:3]); stage 2 applies the 4/2/1-bit levels (shamt[2:0]) and drives the result to the ALU result mux.
- Supports SLL, SRL, SRA and ROTR, and carries a tag so the consumer can match results to instructions.

Parameters:
TAG_W, 5, width of the tag carried alongside each request (e.g. destination register number)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  request present on data/shamt/op/in_tag
in_ready  output  1  unit accepts a request this cycle
data  input  32  operand to shift
shamt  input  5  shift amount 0..31
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right)
in_tag  input  TAG_W  opaque tag
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
dataOut  output  32  shifted result
out_tag  output  TAG_W  tag of the result on dataOut
busy  output  1  high while any stage holds a valid entry

Behaviour:
- Reset (rst low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, dataOut=0, out_tag=0, busy=0. All stage data registers clear to 0.
- in_ready is 1 while rst is low only if it is combinationally derived. It is meaningful only after reset is released.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid, data, shamt, op and in_tag are sampled only on an input transfer.
- Stall chain (combinational):
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - There is no combinational path from in_valid to out_valid.
- Stage 1 register, loaded when s1_adv:
  - s1_valid <= in_valid.
  - When in_valid, it also captures the partial result after the shamt[4] (16) and shamt[3] (8) levels, plus shamt[2:0], op and in_tag.
- Stage 2 register, loaded when s2_adv:
  - s2_valid <= s1_valid.
  - When s1_valid, it also captures the final result after the 4/2/1 levels, plus the tag.
  - out_valid = s2_valid. dataOut and out_tag are the stage 2 registers.
- Hold: when a stage does not advance, its registers hold. dataOut/out_tag stay stable while out_valid && !out_ready.
- Shift levels, per op:
  - SLL fills vacated bits with 0 from the LSB side.
  - SRL fills with 0 from the MSB side.
  - SRA fills with the original data[31]. The sign bit is carried into stage 2 so the fill is correct at every level.
  - ROTR wraps bits shifted out of bit 0 into bit 31.
- Widths: shamt is unsigned 0..31. shamt=0 returns data unchanged for all ops.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to out_valid when out_ready is held high.
  - Throughput is 1 result/cycle with no bubbles under continuous in_valid and out_ready.
- Full pipeline: with both stages valid and out_ready=0, in_ready=0 and nothing moves.
  - When out_ready rises, in the same cycle the output transfers, stage 1 moves to stage 2, and a new input is accepted.
- Ordering: results leave in acceptance order and are never dropped or duplicated.
- busy = s1_valid || s2_valid.
- Reset mid-operation: all in-flight entries are discarded, with out_valid going to 0 immediately (asynchronous). No result emerges after reset deasserts unless a new input is accepted.

Test Plan:
- Basic ops:
  - data=0x0000_00F1, shamt=16, op=SLL -> 2 cycles later out_valid=1, dataOut=0x00F1_0000.
  - Same data, shamt=4, op=SRL -> 0x0000_000F.
- SRA sign fill: data=0x8000_0000, shamt=31, op=SRA -> 0xFFFF_FFFF. data=0x7000_0000, shamt=28 -> 0x0000_0007.
- ROTR and zero shift:
  - data=0x1234_5678, shamt=8, op=ROTR -> 0x7812_3456.
  - shamt=0 for each op -> 0x1234_5678.
- Streaming: 8 back-to-back requests (SLL by 0..7 of 0x1, tags 0..7) with out_ready=1.
  - First result 2 cycles after the first accept, then 1/cycle.
  - dataOut=1<<n, out_tag=n, in order.
- Backpressure:
  - Accept A and B, then hold out_ready=0 -> in_ready=0 and dataOut stable on A. A third request C is held off.
  - Raise out_ready -> A, B, C emerge on consecutive cycles.
- Reset mid-flight: two entries in flight, pull rst low for 1 cycle -> out_valid=0 and busy=0 immediately, and no output afterwards.
